// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings,
// the default operand width and a small sizing helper for the bit counter.
package serial_subtractor_pkg;

   // Default operand/result width when the parent does not override it.
   localparam int DEFAULT_WIDTH = 8;

   // Supported width range.
   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 32;

   // Control FSM states.
   //   IDLE   : waiting for START, result registers hold the last answer
   //   SHIFT  : one bit per clock through the full-subtractor cell
   //   FINISH : one-cycle DONE pulse, may accept a new START
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Bit-counter width: enough to hold WIDTH-1, with one spare bit so the
   // count never has to wrap through zero before the terminal compare.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: DIFF = X - Y - BI, BO set when the bit underflows.
// This is the only arithmetic in the serial datapath; it is used once per bit.
module full_subtractor (
   input  logic X,
   input  logic Y,
   input  logic BI,
   output logic DIFF,
   output logic BO
);

   logic x_eq_y;

   // Difference and borrow equations of a single-bit subtract.
   always_comb begin
      x_eq_y = ~(X ^ Y);
      DIFF   = X ^ Y ^ BI;
      // Borrow when X=0,Y=1, or when the bits are equal and a borrow arrives.
      BO     = (~X & Y) | (x_eq_y & BI);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes D = A - B - BIN (mod 2^WIDTH) and the final
// borrow BOUT, one bit per clock, LSB first. A START accepted in IDLE or
// FINISH captures the operands; WIDTH edges later the result is loaded into
// D/BOUT and DONE pulses for one cycle. D/BOUT hold until the next result.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             BOUT
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t             state_q;
   state_t             state_d;

   logic [WIDTH-1:0]   a_sr;       // minuend, shifted right each SHIFT cycle
   logic [WIDTH-1:0]   b_sr;       // subtrahend, shifted right each SHIFT cycle
   logic [WIDTH-1:0]   d_sr;       // partial difference, filled from the MSB
   logic               borrow_q;   // borrow carried between bit positions
   logic [CNT_W-1:0]   cnt_q;      // index of the bit being processed

   logic [WIDTH-1:0]   d_q;
   logic               bout_q;

   // ---------------------------------------------------------------------
   // Derived control
   // ---------------------------------------------------------------------
   logic               accept;     // START taken this edge
   logic               shifting;
   logic               last_bit;   // final bit is being processed this edge
   logic               cell_diff;
   logic               cell_bo;
   logic [WIDTH-1:0]   d_next;     // shift register contents after this edge

   assign shifting = (state_q == SHIFT);
   // START is ignored while shifting so operands cannot change mid-operation.
   assign accept   = START && !shifting;
   assign last_bit = shifting && (cnt_q == CNT_LAST);
   assign d_next   = {cell_diff, d_sr[WIDTH-1:1]};

   // ---------------------------------------------------------------------
   // Per-bit arithmetic cell
   // ---------------------------------------------------------------------
   full_subtractor u_cell (
      .X    (a_sr[0]),
      .Y    (b_sr[0]),
      .BI   (borrow_q),
      .DIFF (cell_diff),
      .BO   (cell_bo)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   // Holds the control state; reset forces IDLE immediately, without a clock.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else begin
         // NOTE: clocked state uses <= so every register samples the
         // pre-edge values of the others, whatever the block order.
         state_q <= state_d;
      end
   end

   // FSM: next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (START) state_d = SHIFT;
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) state_d = FINISH;
         end
         FINISH: begin
            // Back-to-back: a START here goes straight into the next operation.
            state_d = START ? SHIFT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs decoded purely from the current state.
   always_comb begin
      BUSY = 1'b0;
      DONE = 1'b0;
      case (state_q)
         SHIFT:   BUSY = 1'b1;
         FINISH:  DONE = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   // Operand shift registers: loaded on accept, shifted one bit per SHIFT edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_sr <= '0;
         b_sr <= '0;
      end else if (accept) begin
         a_sr <= A;
         b_sr <= B;
      end else if (shifting) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
      end
   end

   // Borrow flop: seeded with BIN on accept, then carries the cell borrow.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         borrow_q <= 1'b0;
      end else if (accept) begin
         borrow_q <= BIN;
      end else if (shifting) begin
         borrow_q <= cell_bo;
      end
   end

   // Bit counter: 0..WIDTH-1, cleared on accept and again at the terminal count.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else if (accept || last_bit) begin
         cnt_q <= '0;
      end else if (shifting) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   // Result shift register: each new difference bit enters at the MSB so the
   // LSB computed first ends up at bit 0 after WIDTH shifts.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         d_sr <= '0;
      end else if (shifting) begin
         d_sr <= d_next;
      end
   end

   // Output registers: updated only at the completion edge, held otherwise.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         d_q    <= '0;
         bout_q <= 1'b0;
      end else if (last_bit) begin
         d_q    <= d_next;
         bout_q <= cell_bo;
      end
   end

   assign D    = d_q;
   assign BOUT = bout_q;

endmodule
